// File: rtl/conv_controller_pipelined.sv
// Loop-nest controller for the convolution accelerator: fetches weights and activations,
// issues MACs and tracks each result through a latency pipeline to memory write-back or output.
module conv_controller_pipelined #(
  parameter int unsigned LOG2_OF_MEM_HEIGHT = 20,
  parameter int unsigned FEATURE_MAP_WIDTH  = 16,
  parameter int unsigned FEATURE_MAP_HEIGHT = 16,
  parameter int unsigned INPUT_NB_CHANNELS  = 4,
  parameter int unsigned OUTPUT_NB_CHANNELS = 4,
  parameter int unsigned K_STEPS            = 2,
  parameter int unsigned WEIGHT_WORDS       = 2,
  parameter int unsigned PIPE_LATENCY       = 5
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  output logic                          running,
  output logic                          done,
  input  logic                          valid,
  output logic                          ready,
  output logic [K_STEPS-1:0]            write_a,
  output logic [WEIGHT_WORDS-1:0]       write_b,
  output logic                          mac_valid,
  output logic                          mac_accumulate_with_0,
  output logic                          pipe_en,
  output logic                          mem_re,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
  output logic                          mem_we,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
  output logic                          output_valid,
  input  logic                          output_ready,
  output logic [31:0]                   output_x,
  output logic [31:0]                   output_y,
  output logic [31:0]                   output_ch
);

  localparam int unsigned AW = LOG2_OF_MEM_HEIGHT;

  typedef enum logic [2:0] {StIdle, StFetchW, StMac, StDrain, StDone} state_e;

  typedef struct packed {
    logic          vld;
    logic          is_final;
    logic [AW-1:0] addr;
    logic [31:0]   x;
    logic [31:0]   y;
    logic [31:0]   ch;
  } entry_t;

  state_e      state_q, state_d;
  logic [31:0] ci_q, ci_d, co_q, co_d, y_q, y_d, x_q, x_d, k_q, k_d, w_q, w_d;
  entry_t      pipe_q [PIPE_LATENCY];
  entry_t      tail, issue_entry;
  logic        stall, accept, issue, any_valid, last_px, last_all;
  logic [31:0] lin_addr;

  assign tail           = pipe_q[PIPE_LATENCY-1];
  assign output_valid   = tail.vld && tail.is_final;
  assign mem_we         = tail.vld && !tail.is_final;
  assign mem_write_addr = mem_we ? tail.addr : '0;
  assign output_x       = output_valid ? tail.x : '0;
  assign output_y       = output_valid ? tail.y : '0;
  assign output_ch      = output_valid ? tail.ch : '0;
  assign stall          = output_valid && !output_ready;
  assign running        = (state_q != StIdle);
  assign pipe_en        = running && !stall;

  assign lin_addr = (co_q * FEATURE_MAP_HEIGHT + y_q) * FEATURE_MAP_WIDTH + x_q;
  assign last_px  = (x_q == FEATURE_MAP_WIDTH - 1) && (y_q == FEATURE_MAP_HEIGHT - 1);
  assign last_all = last_px && (co_q == OUTPUT_NB_CHANNELS - 1) &&
                    (ci_q == INPUT_NB_CHANNELS - 1);

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < int'(PIPE_LATENCY); i++) any_valid = any_valid | pipe_q[i].vld;
  end

  always_comb begin
    state_d               = state_q;
    ci_d                  = ci_q;
    co_d                  = co_q;
    y_d                   = y_q;
    x_d                   = x_q;
    k_d                   = k_q;
    w_d                   = w_q;
    ready                 = 1'b0;
    accept                = 1'b0;
    issue                 = 1'b0;
    write_a               = '0;
    write_b               = '0;
    mac_valid             = 1'b0;
    mac_accumulate_with_0 = 1'b0;
    mem_re                = 1'b0;
    mem_read_addr         = '0;
    done                  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetchW;
          ci_d = '0;
          co_d = '0;
          y_d  = '0;
          x_d  = '0;
          k_d  = '0;
          w_d  = '0;
        end
      end
      StFetchW: begin
        ready  = !stall;
        accept = valid && ready;
        if (accept) begin
          for (int i = 0; i < int'(WEIGHT_WORDS); i++) write_b[i] = (w_q == 32'(i));
          if (w_q == WEIGHT_WORDS - 1) begin
            w_d     = '0;
            state_d = StMac;
          end else begin
            w_d = w_q + 1;
          end
        end
      end
      StMac: begin
        ready  = !stall;
        accept = valid && ready;
        if (accept) begin
          for (int i = 0; i < int'(K_STEPS); i++) write_a[i] = (k_q == 32'(i));
          mac_valid             = 1'b1;
          mac_accumulate_with_0 = (ci_q == 0) && (k_q == 0);
          if (k_q == K_STEPS - 1) begin
            issue         = 1'b1;
            mem_re        = 1'b1;
            mem_read_addr = AW'(lin_addr);
            k_d           = '0;
            // Innermost-to-outermost carry chain: x, y, ch_out, ch_in.
            if (x_q == FEATURE_MAP_WIDTH - 1) begin
              x_d = '0;
              if (y_q == FEATURE_MAP_HEIGHT - 1) begin
                y_d = '0;
                if (co_q == OUTPUT_NB_CHANNELS - 1) begin
                  co_d = '0;
                  ci_d = (ci_q == INPUT_NB_CHANNELS - 1) ? '0 : ci_q + 1;
                end else begin
                  co_d = co_q + 1;
                end
              end else begin
                y_d = y_q + 1;
              end
            end else begin
              x_d = x_q + 1;
            end
            if (last_all) state_d = StDrain;
            else if (last_px) state_d = StFetchW;
          end else begin
            k_d = k_q + 1;
          end
        end
      end
      StDrain: begin
        if (!any_valid) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue_entry = '0;
    if (issue) begin
      issue_entry.vld      = 1'b1;
      issue_entry.is_final = (ci_q == INPUT_NB_CHANNELS - 1);
      issue_entry.addr     = AW'(lin_addr);
      issue_entry.x        = x_q;
      issue_entry.y        = y_q;
      issue_entry.ch       = co_q;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q <= StIdle;
      ci_q    <= '0;
      co_q    <= '0;
      y_q     <= '0;
      x_q     <= '0;
      k_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      ci_q    <= ci_d;
      co_q    <= co_d;
      y_q     <= y_d;
      x_q     <= x_d;
      k_q     <= k_d;
      w_q     <= w_d;
    end
  end

  // The whole result pipeline freezes with the controller while the output is stalled.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < int'(PIPE_LATENCY); i++) pipe_q[i] <= '0;
    end else if (pipe_en) begin
      pipe_q[0] <= issue_entry;
      for (int i = 1; i < int'(PIPE_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

endmodule
